// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage.
// Contents:
//   - funct3 encodings for loads and stores
//   - FSM state type
//   - data-memory byte-lane count
//   - helpers that derive byte-lane masks and alignment from an access size
package mem_pkg;

  localparam int LANES = 8;

  // Load encodings. funct3[1:0] is the size and funct3[2] selects zero-extension.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store encodings. These share their size field with the loads.
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  // Byte-lane mask for an access of 2**size bytes, before the lane shift.
  function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // An access is misaligned when the offset is not a multiple of its size.
  function automatic logic misaligned_for(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Request signals:
//   - req   : access request
//   - we    : store when high
//   - addr  : 8-byte-aligned address
//   - wdata : lane-shifted store data
//   - be    : byte enables
// Response signals:
//   - ack   : access done
//   - rdata : 8-byte-aligned read data, valid together with ack
interface memory_stage_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);

  logic                       req;
  logic                       we;
  logic [ADDR_WIDTH-1:0]      addr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [mem_pkg::LANES-1:0]  be;
  logic                       ack;
  logic [DATA_WIDTH-1:0]      rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/memory_stage_load_align.sv
// Load formatting. The module is purely combinational.
// Ports:
//   - rdata  : 8-byte-aligned word from data memory
//   - offset : byte offset of the access within that word
//   - funct3 : load size and signedness
//   - data   : the loaded value, right-justified and extended
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   data = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      F3_LWU:  data = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage. Issues loads and stores to data memory and stalls
// upstream until the memory acknowledges. It then registers the results into
// the memory/writeback register.
// Ports:
//   - i_clk, i_arst     : clock and asynchronous active-low reset
//   - i_*               : execute-register fields, plus i_flush to squash the
//                         next writeback entry
//   - dmem              : data-memory bus (master side)
//   - o_stall           : freeze upstream
//   - o_misaligned      : misaligned access detected
//   - o_*               : memory/writeback register
module memory_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_valid,
  input  logic [2:0]            i_result_src,
  input  logic                  i_mem_we,
  input  logic                  i_reg_we,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_mem_re,
  input  logic [2:0]            i_funct3,
  input  logic                  i_flush,
  memory_stage_if.master        dmem,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic                  o_valid,
  output logic [2:0]            o_result_src,
  output logic                  o_reg_we,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [REG_ADDR_W-1:0] o_rd_addr
);

  state_t                state, state_next;
  logic                  access, is_load, misaligned, aligned_access, pending;
  logic                  flush_hold, bubble;
  logic [1:0]            size;
  logic [2:0]            offset;
  logic [DATA_WIDTH-1:0] wmask, load_data;

  assign size   = i_funct3[1:0];
  assign offset = i_alu_result[2:0];

  // When both we and re are set, the access is treated as a store.
  assign access         = i_valid & (i_mem_we | i_mem_re);
  assign is_load        = i_mem_re & ~i_mem_we;
  assign misaligned     = access & misaligned_for(size, offset);
  assign aligned_access = access & ~misaligned;
  assign o_misaligned   = misaligned;

  // Request fields come straight from the execute register. Upstream is
  // frozen by o_stall while the access waits, so these fields stay stable
  // in WAIT_ACK. Gating req with the reset drops it at once when reset is
  // asserted mid-wait.
  assign dmem.req  = i_arst & ((state == WAIT_ACK) | aligned_access);
  assign dmem.we   = i_mem_we;
  assign dmem.addr = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
  assign dmem.be   = size_mask(size) << offset;

  // Keep only the low size bytes of the store data, then move them to their lane.
  always_comb begin
    case (size)
      2'd0:    wmask = DATA_WIDTH'(8'hFF);
      2'd1:    wmask = DATA_WIDTH'(16'hFFFF);
      2'd2:    wmask = DATA_WIDTH'(32'hFFFF_FFFF);
      default: wmask = '1;
    endcase
  end
  assign dmem.wdata = (i_write_data & wmask) << {offset, 3'b000};

  assign pending = dmem.req;
  assign o_stall = pending & ~dmem.ack;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next-state logic. An ack arriving in the request cycle completes
  // the access without entering WAIT_ACK.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (pending && !dmem.ack) state_next = WAIT_ACK;
      WAIT_ACK: if (dmem.ack)             state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata  (dmem.rdata),
    .offset (offset),
    .funct3 (i_funct3),
    .data   (load_data)
  );

  // A flush seen while stalled is remembered until the register can take
  // the bubble. The stalled access itself runs to completion.
  assign bubble = misaligned | i_flush | flush_hold;

  // Memory/writeback register. It holds its value while stalled.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      flush_hold   <= 1'b0;
      o_valid      <= 1'b0;
      o_result_src <= '0;
      o_reg_we     <= 1'b0;
      o_pc_plus4   <= '0;
      o_pc_target  <= '0;
      o_imm_ext    <= '0;
      o_alu_result <= '0;
      o_read_data  <= '0;
      o_rd_addr    <= '0;
    end else if (!o_stall) begin
      flush_hold   <= 1'b0;
      o_valid      <= i_valid & ~bubble;
      o_result_src <= i_result_src;
      o_reg_we     <= i_reg_we & ~bubble;
      o_pc_plus4   <= i_pc_plus4;
      o_pc_target  <= i_pc_target;
      o_imm_ext    <= i_imm_ext;
      o_alu_result <= i_alu_result;
      o_read_data  <= (aligned_access && is_load) ? load_data : '0;
      o_rd_addr    <= i_rd_addr;
    end else if (i_flush) begin
      flush_hold   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage.
// Structure:
//   - Directed vectors push their expected writeback entry into a scoreboard
//     queue.
//   - A monitor pops and compares an entry on every edge where the DUT
//     captures an issued instruction.
//   - A simple memory responder acks requests after a programmable delay.
module tb_memory_stage;
  import mem_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b0;
  logic        i_valid, i_mem_we, i_reg_we, i_mem_re, i_flush;
  logic [2:0]  i_result_src, i_funct3;
  logic [63:0] i_pc_plus4, i_pc_target, i_imm_ext, i_alu_result, i_write_data;
  logic [4:0]  i_rd_addr;
  logic        o_stall, o_misaligned, o_valid, o_reg_we;
  logic [2:0]  o_result_src;
  logic [63:0] o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result, o_read_data;
  logic [4:0]  o_rd_addr;

  memory_stage_if dmem ();

  memory_stage dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_valid(i_valid), .i_result_src(i_result_src),
    .i_mem_we(i_mem_we), .i_reg_we(i_reg_we), .i_pc_plus4(i_pc_plus4),
    .i_pc_target(i_pc_target), .i_imm_ext(i_imm_ext), .i_alu_result(i_alu_result),
    .i_write_data(i_write_data), .i_rd_addr(i_rd_addr), .i_mem_re(i_mem_re),
    .i_funct3(i_funct3), .i_flush(i_flush), .dmem(dmem), .o_stall(o_stall),
    .o_misaligned(o_misaligned), .o_valid(o_valid), .o_result_src(o_result_src),
    .o_reg_we(o_reg_we), .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target),
    .o_imm_ext(o_imm_ext), .o_alu_result(o_alu_result), .o_read_data(o_read_data),
    .o_rd_addr(o_rd_addr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        bubble;
    logic        valid;
    logic        reg_we;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] read_data;
    logic [63:0] pc_plus4;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        issued = 1'b0;
  logic        responder_on = 1'b1;
  int          ack_delay = 0;
  logic [63:0] mem_rdata = '0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%h required=0x%h", name, actual, required);
    end
  endtask

  task automatic set_inputs(input logic [2:0] f3, input logic we, input logic re, input logic rwe,
                            input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    i_valid      = 1'b1;
    i_funct3     = f3;
    i_mem_we     = we;
    i_mem_re     = re;
    i_reg_we     = rwe;
    i_alu_result = addr;
    i_write_data = wd;
    i_rd_addr    = rd;
    i_pc_plus4   = addr + 64'd4;
    i_pc_target  = addr + 64'h40;
    i_imm_ext    = 64'h10;
    i_result_src = 3'b010;
  endtask

  task automatic set_idle();
    i_valid  = 1'b0;
    i_mem_we = 1'b0;
    i_mem_re = 1'b0;
    i_reg_we = 1'b0;
    i_flush  = 1'b0;
  endtask

  // Memory responder: acks after ack_delay wait cycles and returns mem_rdata.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge i_clk);
      if (!responder_on) begin
        cnt = 0;
      end else begin
        if (dmem.ack) begin
          dmem.ack = 1'b0;
          cnt = 0;
        end
        if (dmem.req) begin
          if (cnt >= ack_delay) begin
            dmem.ack   = 1'b1;
            dmem.rdata = mem_rdata;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Monitor: compares every writeback entry captured for an issued instruction.
  initial begin
    logic cap;
    exp_t e;
    forever begin
      @(posedge i_clk);
      cap = issued && !o_stall && i_arst;
      #1;
      if (cap) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_capture actual=entry required=none");
        end else begin
          e = sb.pop_front();
          check_output("wb_valid", o_valid, e.valid);
          check_output("wb_reg_we", o_reg_we, e.reg_we);
          if (!e.bubble) begin
            check_output("wb_rd", o_rd_addr, e.rd);
            check_output("wb_alu", o_alu_result, e.alu);
            check_output("wb_read_data", o_read_data, e.read_data);
            check_output("wb_pc_plus4", o_pc_plus4, e.pc_plus4);
            check_output("wb_result_src", o_result_src, 3'b010);
          end
        end
      end
    end
  end

  // Issue one instruction and check the bus side each cycle until it retires.
  task automatic apply_stimulus(input string name, input logic [2:0] f3, input logic we, input logic re,
                                input logic rwe, input logic [63:0] addr, input logic [63:0] wd,
                                input logic [4:0] rd, input logic [63:0] rdata, input int delay,
                                input logic flush_in_wait, input logic exp_req, input logic exp_mis,
                                input logic [7:0] exp_be, input logic [63:0] exp_wd, input int exp_stalls,
                                input logic exp_bubble, input logic [63:0] exp_read);
    exp_t e;
    int   stalls;
    logic done;
    ack_delay = delay;
    mem_rdata = rdata;
    set_inputs(f3, we, re, rwe, addr, wd, rd);
    issued      = 1'b1;
    e.bubble    = exp_bubble;
    e.valid     = !exp_bubble;
    e.reg_we    = exp_bubble ? 1'b0 : rwe;
    e.rd        = rd;
    e.alu       = addr;
    e.read_data = exp_read;
    e.pc_plus4  = addr + 64'd4;
    sb.push_back(e);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      #1;
      check_output({name, " req"}, dmem.req, exp_req);
      check_output({name, " misaligned"}, o_misaligned, exp_mis);
      if (exp_req) begin
        check_output({name, " addr"}, dmem.addr, {addr[63:3], 3'b000});
        check_output({name, " be"}, dmem.be, exp_be);
        check_output({name, " we"}, dmem.we, we);
        if (we) check_output({name, " wdata"}, dmem.wdata, exp_wd);
      end
      if (!o_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (flush_in_wait && stalls == 1) i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout actual=stalled required=ack", name);
    end
    check_output({name, " stall_cycles"}, stalls, exp_stalls);
    @(posedge i_clk);
    #1;
    set_idle();
    issued = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    set_inputs(3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    set_idle();
    #12;
    check_output("reset valid", o_valid, 1'b0);
    check_output("reset read_data", o_read_data, 64'h0);
    check_output("reset alu", o_alu_result, 64'h0);
    check_output("reset req", dmem.req, 1'b0);
    check_output("reset stall", o_stall, 1'b0);
    @(negedge i_clk);
    i_arst = 1'b1;
    @(posedge i_clk);
    #1;

    //            name    f3      we    re    rwe   addr             wdata                   rd     rdata                  dly fl  req   mis   be     exp_wdata               st bub   exp_read
    apply_stimulus("alu",  F3_LB,  1'b0, 1'b0, 1'b1, 64'h1234, 64'h0, 5'd5, 64'h0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 0, 1'b0, 64'h0);
    apply_stimulus("lb",   F3_LB,  1'b0, 1'b1, 1'b1, 64'h103, 64'h0, 5'd6, 64'h00000000_80000000, 0, 1'b0, 1'b1, 1'b0, 8'h08, 64'h0, 0, 1'b0, 64'hFFFFFFFF_FFFFFF80);
    apply_stimulus("lwu",  F3_LWU, 1'b0, 1'b1, 1'b1, 64'h104, 64'h0, 5'd7, 64'h89ABCDEF_00000000, 3, 1'b0, 1'b1, 1'b0, 8'hF0, 64'h0, 3, 1'b0, 64'h00000000_89ABCDEF);
    apply_stimulus("sh",   F3_SH,  1'b1, 1'b0, 1'b0, 64'h106, 64'hBEEF, 5'd0, 64'h0, 0, 1'b0, 1'b1, 1'b0, 8'hC0, 64'hBEEF0000_00000000, 0, 1'b0, 64'h0);
    apply_stimulus("lw_mis", F3_LW, 1'b0, 1'b1, 1'b1, 64'h102, 64'h0, 5'd8, 64'h0, 0, 1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 0, 1'b1, 64'h0);
    apply_stimulus("lh",   F3_LH,  1'b0, 1'b1, 1'b1, 64'h102, 64'h0, 5'd9, 64'h00000000_80010000, 1, 1'b0, 1'b1, 1'b0, 8'h0C, 64'h0, 1, 1'b0, 64'hFFFFFFFF_FFFF8001);
    apply_stimulus("lbu",  F3_LBU, 1'b0, 1'b1, 1'b1, 64'h10F, 64'h0, 5'd10, 64'hFE000000_00000000, 0, 1'b0, 1'b1, 1'b0, 8'h80, 64'h0, 0, 1'b0, 64'h00000000_000000FE);
    apply_stimulus("sb",   F3_SB,  1'b1, 1'b0, 1'b0, 64'h101, 64'h123456AB, 5'd0, 64'h0, 0, 1'b0, 1'b1, 1'b0, 8'h02, 64'h00000000_0000AB00, 0, 1'b0, 64'h0);
    apply_stimulus("ld",   F3_LD,  1'b0, 1'b1, 1'b1, 64'h108, 64'h0, 5'd11, 64'h01234567_89ABCDEF, 2, 1'b0, 1'b1, 1'b0, 8'hFF, 64'h0, 2, 1'b0, 64'h01234567_89ABCDEF);
    apply_stimulus("sd_mis", F3_SD, 1'b1, 1'b0, 1'b0, 64'h104, 64'h55, 5'd0, 64'h0, 0, 1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 0, 1'b1, 64'h0);
    apply_stimulus("lw",   F3_LW,  1'b0, 1'b1, 1'b1, 64'h10C, 64'h0, 5'd12, 64'h80000000_00000000, 0, 1'b0, 1'b1, 1'b0, 8'hF0, 64'h0, 0, 1'b0, 64'hFFFFFFFF_80000000);
    apply_stimulus("we_re", F3_SD, 1'b1, 1'b1, 1'b0, 64'h118, 64'h1111, 5'd0, 64'hFFFF, 0, 1'b0, 1'b1, 1'b0, 8'hFF, 64'h1111, 0, 1'b0, 64'h0);
    apply_stimulus("sw_flush", F3_SW, 1'b1, 1'b0, 1'b0, 64'h10C, 64'hCAFEF00D_DEADBEEF, 5'd0, 64'h0, 2, 1'b1, 1'b1, 1'b0, 8'hF0, 64'hDEADBEEF_00000000, 2, 1'b1, 64'h0);

    // Reset in the middle of a long store wait.
    ack_delay = 50;
    set_inputs(F3_SW, 1'b1, 1'b0, 1'b0, 64'h110, 64'h77, 5'd0);
    @(negedge i_clk);
    #1;
    check_output("rst_wait stall", o_stall, 1'b1);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    #1;
    check_output("rst_wait req_before", dmem.req, 1'b1);
    check_output("rst_wait alu_before", o_alu_result, 64'h10C);
    i_arst = 1'b0;
    #1;
    check_output("rst_wait req", dmem.req, 1'b0);
    check_output("rst_wait stall_after", o_stall, 1'b0);
    check_output("rst_wait alu", o_alu_result, 64'h0);
    check_output("rst_wait pc_plus4", o_pc_plus4, 64'h0);
    check_output("rst_wait valid", o_valid, 1'b0);
    set_idle();
    responder_on = 1'b0;
    dmem.ack = 1'b1;
    @(negedge i_clk);
    i_arst = 1'b1;
    #1;
    check_output("stale_ack req", dmem.req, 1'b0);
    check_output("stale_ack stall", o_stall, 1'b0);
    @(posedge i_clk);
    #1;
    check_output("stale_ack valid", o_valid, 1'b0);
    dmem.ack = 1'b0;
    responder_on = 1'b1;
    apply_stimulus("alu_post", F3_LB, 1'b0, 1'b0, 1'b1, 64'h55, 64'h0, 5'd7, 64'h0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 0, 1'b0, 64'h0);

    @(posedge i_clk);
    #2;
    check_output("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
